pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multicycle fetch/PC controller for the LEGv8 core. It owns the program-counter register, issues instruction-memory fetches with a request/acknowledge handshake, presents each fetched instruction to decode, and commits the next PC (sequential or branch target) once execute reports completion. It sits between instruction memory and the decode/execute datapath, and replaces the free-running single-cycle PC update.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  holds the sequencer in IDLE and masks ExecDone while high.
- imem_req  out  1  fetch request; held until acknowledged.
- imem_addr  out  64  fetch address; always equals CurrentPC.
- imem_ack  in  1  instruction memory has valid data on imem_data this cycle.
- imem_data  in  32  fetched instruction word.
- Instruction  out  32  registered instruction presented to decode.
- InstrValid  out  1  Instruction is valid and awaiting ExecDone.
- ExecDone  in  1  execute finished; branch inputs are valid this cycle.
- Branch  in  1  conditional branch (CBZ-type).
- ALUZero  in  1  ALU zero flag.
- Uncondbranch  in  1  unconditional branch.
- SignExtImm64  in  64  byte offset, already shifted by the datapath.
- CurrentPC  out  64  architectural PC register.
- RetireCount  out  32  count of accepted ExecDone events.
- Fault  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: no request. Moves to FETCH when Stall=0.
- FETCH: imem_req=1 and imem_addr=CurrentPC. On imem_ack=1, latch imem_data into Instruction and move to ISSUE. Once asserted, the request is not withdrawn because of Stall.
- ISSUE: InstrValid=1. On ExecDone=1 with Stall=0:
  - Load PC with the next value.
  - Increment RetireCount.
  - Move to FETCH.
  - ExecDone while Stall=1 is ignored, and the state holds.
- Next-PC rule:
  - taken = (Branch & ALUZero) | Uncondbranch.
  - If taken, next = CurrentPC + SignExtImm64; otherwise next = CurrentPC + 4.
  - Both sums are modulo 2^64 and wrap silently.
- RetireCount wraps from 32'hFFFFFFFF to 0.
- imem_ack outside FETCH (stray or late) is ignored.
- HALT: entered only on a fault (macro enabled). No requests are issued, and only Reset leaves this state.

## Timing
- Reset values: state IDLE, CurrentPC=imem_addr=RESET_PC, imem_req=0, Instruction=0, InstrValid=0, RetireCount=0, Fault=0.
- Reset takes priority over every other input. Reset asserted mid-FETCH drops imem_req at the next edge, and any ack after that is discarded.
- Fetch latency: FETCH entered at cycle t. An ack at cycle t+k (k≥0) gives InstrValid=1 at t+k+1.
- Commit latency: ExecDone at cycle u gives the new CurrentPC and imem_req=1 at u+1.
- Minimum loop is 2 cycles per instruction (ack in the first FETCH cycle, ExecDone in the first ISSUE cycle).
- InstrValid deasserts in the cycle after the accepted ExecDone.

## Configuration
- PC_SEQ_ALIGN_CHECK_EN defined:
  - If the computed next PC has bits [1:0]≠0 on commit, the PC is not updated and RetireCount still increments.
  - Fault is set to 1 and the sequencer enters HALT.
  - Fault clears only on Reset.
- PC_SEQ_ALIGN_CHECK_EN not defined:
  - The next PC is loaded unchanged, with no check.
  - Fault is tied to 0 and HALT is unreachable.

## Structure
- Package pc_seq_pkg holds:
  - the state enum (IDLE, FETCH, ISSUE, HALT);
  - PC_INCR=64'd4;
  - widths PC_W=64, INSTR_W=32, CNT_W=32.
- One combinational sub-module, next_pc_calc, computes taken, the next PC, and the misaligned flag from CurrentPC, SignExtImm64, Branch, ALUZero and Uncondbranch. The FSM and registers stay in pc_sequencer.

## Test plan
- Reset with RESET_PC=64'h100, Stall=0, ack after 2 cycles, data 32'h8B020020, ExecDone with no branch -> InstrValid 3 cycles after FETCH entry, Instruction=32'h8B020020, CurrentPC=64'h104, RetireCount=1.
- PC=64'h200, ExecDone with Branch=1, ALUZero=1, SignExtImm64=-64'd16 -> CurrentPC=64'h1F0. Repeat with ALUZero=0 -> 64'h204. Repeat with Uncondbranch=1, offset 64'h40 -> 64'h244.
- PC=64'hFFFFFFFFFFFFFFFC, sequential commit -> CurrentPC=0 (wrap), no Fault.
- Stall=1 during ISSUE with ExecDone=1 for 3 cycles -> PC unchanged and RetireCount unchanged. Stall drops -> commit on that cycle.
- Reset asserted mid-FETCH, then ack next cycle -> imem_req=0, state IDLE, Instruction=0, ack ignored.
- With macro enabled, offset 64'h6 taken -> Fault=1, PC unchanged, imem_req stays 0 until Reset. With macro disabled -> PC=old+6, Fault=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the LEGv8 fetch/PC sequencer.
package pc_seq_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 32;

    localparam logic [PC_W-1:0] PC_INCR = 64'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: branch decision, target/sequential sum
// and the word-alignment flag of the chosen address.
module next_pc_calc
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] current_pc,
    input  logic [PC_W-1:0] sign_ext_imm64,
    input  logic            branch,
    input  logic            alu_zero,
    input  logic            uncondbranch,
    output logic            taken,
    output logic [PC_W-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        taken      = (branch & alu_zero) | uncondbranch;
        // Both sums wrap modulo 2^64 by construction of the 64-bit add.
        next_pc    = taken ? (current_pc + sign_ext_imm64) : (current_pc + PC_INCR);
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/PC controller: owns the PC, fetches over a req/ack
// handshake, commits the next PC on ExecDone. Optional PC_SEQ_ALIGN_CHECK_EN
// halts on a misaligned commit target and raises a sticky Fault.
//
// state | meaning
// IDLE  | no request; leaves when Stall is low
// FETCH | imem_req high at CurrentPC until imem_ack
// ISSUE | Instruction valid, waiting for an unstalled ExecDone
// HALT  | misaligned target seen; only Reset leaves
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Stall,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    input  logic               ExecDone,
    input  logic               Branch,
    input  logic               ALUZero,
    input  logic               Uncondbranch,
    input  logic [PC_W-1:0]    SignExtImm64,
    output logic [PC_W-1:0]    CurrentPC,
    output logic [CNT_W-1:0]   RetireCount,
    output logic               Fault
);

    seq_state_t         state, state_nxt;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   retire_q;

    logic               ld_instr;
    logic               ld_pc;
    logic               commit;
    logic               set_fault;

    logic               taken;
    logic [PC_W-1:0]    next_pc;
    logic               misaligned;

    next_pc_calc u_next_pc_calc (
        .current_pc     (pc_q),
        .sign_ext_imm64 (SignExtImm64),
        .branch         (Branch),
        .alu_zero       (ALUZero),
        .uncondbranch   (Uncondbranch),
        .taken          (taken),
        .next_pc        (next_pc),
        .misaligned     (misaligned)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            retire_q <= '0;
        end else begin
            state <= state_nxt;
            if (ld_instr) instr_q  <= imem_data;
            if (ld_pc)    pc_q     <= next_pc;
            if (commit)   retire_q <= retire_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        ld_instr  = 1'b0;
        ld_pc     = 1'b0;
        commit    = 1'b0;
        set_fault = 1'b0;
        case (state)
            IDLE: begin
                if (!Stall) state_nxt = FETCH;
            end
            // Stall is deliberately not looked at here: a raised request stays up.
            FETCH: begin
                if (imem_ack) begin
                    ld_instr  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (ExecDone && !Stall) begin
                    commit = 1'b1;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                    if (misaligned) begin
                        set_fault = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        ld_pc     = 1'b1;
                        state_nxt = FETCH;
                    end
`else
                    ld_pc     = 1'b1;
                    state_nxt = FETCH;
`endif
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic fault_q;
    logic unused_taken;

    always_ff @(posedge CLK) begin
        if (Reset)          fault_q <= 1'b0;
        else if (set_fault) fault_q <= 1'b1;
    end

    assign Fault        = fault_q;
    assign unused_taken = taken;
`else
    logic [2:0] unused_flags;

    assign Fault        = 1'b0;
    assign unused_flags = {taken, misaligned, set_fault};
`endif

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc_q;
    assign InstrValid  = (state == ISSUE);
    assign Instruction = instr_q;
    assign CurrentPC   = pc_q;
    assign RetireCount = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a transaction-level PC/count model.
module tb_pc_sequencer;

    localparam logic [63:0] RST_PC = 64'h100;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        ExecDone = 1'b0;
    logic        Branch = 1'b0;
    logic        ALUZero = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic [63:0] SignExtImm64 = '0;
    logic [63:0] CurrentPC;
    logic [31:0] RetireCount;
    logic        Fault;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_fault;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Stall        (Stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .ExecDone     (ExecDone),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .SignExtImm64 (SignExtImm64),
        .CurrentPC    (CurrentPC),
        .RetireCount  (RetireCount),
        .Fault        (Fault)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic b,
                                             input logic z, input logic u,
                                             input logic [63:0] imm);
        if ((b && z) || u) return pc + imm;
        return pc + 64'd4;
    endfunction

    // Entered in a FETCH cycle; ack after k cycles, returns in the first ISSUE cycle.
    task automatic fetch(input logic [31:0] data, input int k);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            miscompares++;
            $display("FAIL fetch_entry: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, m_pc);
        end
        for (int i = 0; i < k; i++) begin
            step();
            vectors++;
            if (InstrValid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== m_pc) begin
                miscompares++;
                $display("FAIL fetch_wait: valid=%b req=%b addr=%h, required 0/1/%h", InstrValid, imem_req, imem_addr, m_pc);
            end
        end
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
        imem_data = $urandom;
        vectors++;
        if (InstrValid !== 1'b1 || Instruction !== data || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_done: valid=%b instr=%h req=%b, required 1/%h/0", InstrValid, Instruction, imem_req, data);
        end
    endtask

    // Entered in an ISSUE cycle; one ExecDone, checks the cycle after.
    task automatic commit(input logic b, input logic z, input logic u, input logic [63:0] imm);
        logic [63:0] nxt;
        logic        exp_req;
        nxt = ref_next(m_pc, b, z, u, imm);
        Stall = 1'b0; ExecDone = 1'b1; Branch = b; ALUZero = z; Uncondbranch = u; SignExtImm64 = imm;
        step();
        ExecDone = 1'b0; Branch = 1'b0; ALUZero = 1'b0; Uncondbranch = 1'b0; SignExtImm64 = $urandom;
        m_cnt = m_cnt + 32'd1;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        if (nxt[1:0] != 2'b00) m_fault = 1'b1;
        else                   m_pc = nxt;
`else
        m_pc = nxt;
`endif
        exp_req = !m_fault;
        vectors++;
        if (CurrentPC !== m_pc || RetireCount !== m_cnt || imem_req !== exp_req ||
            InstrValid !== 1'b0 || Fault !== m_fault) begin
            miscompares++;
            $display("FAIL commit: pc=%h cnt=%0d req=%b valid=%b fault=%b, required pc=%h cnt=%0d req=%b valid=0 fault=%b",
                     CurrentPC, RetireCount, imem_req, InstrValid, Fault, m_pc, m_cnt, exp_req, m_fault);
        end
    endtask

    task automatic goto_pc(input logic [63:0] target);
        fetch($urandom, 0);
        commit(1'b0, 1'b0, 1'b1, target - m_pc);
    endtask

    task automatic apply_reset();
        Reset = 1'b1; Stall = 1'b0; imem_ack = 1'b0; ExecDone = 1'b0;
        step();
        step();
        m_pc = RST_PC; m_cnt = '0; m_fault = 1'b0;
        vectors++;
        if (imem_req !== 1'b0 || CurrentPC !== RST_PC || imem_addr !== RST_PC || Instruction !== 32'h0 ||
            InstrValid !== 1'b0 || RetireCount !== 32'h0 || Fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: req=%b pc=%h addr=%h instr=%h valid=%b cnt=%0d fault=%b",
                     imem_req, CurrentPC, imem_addr, Instruction, InstrValid, RetireCount, Fault);
        end
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        vectors++;
        if (imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_to_fetch: req=%b, required 1", imem_req);
        end
    endtask

    task automatic test_basic();
        fetch(32'h8B020020, 2);
        commit(1'b0, 1'b0, 1'b0, 64'h0);
        vectors++;
        if (CurrentPC !== 64'h104 || RetireCount !== 32'd1) begin
            miscompares++;
            $display("FAIL basic_seq: pc=%h cnt=%0d, required 104/1", CurrentPC, RetireCount);
        end
    endtask

    task automatic test_branch();
        goto_pc(64'h200);
        fetch($urandom, 1);
        commit(1'b1, 1'b1, 1'b0, -64'd16);
        vectors++;
        if (CurrentPC !== 64'h1F0) begin
            miscompares++;
            $display("FAIL cbz_taken: pc=%h, required 1f0", CurrentPC);
        end
        goto_pc(64'h200);
        fetch($urandom, 0);
        commit(1'b1, 1'b0, 1'b0, -64'd16);
        vectors++;
        if (CurrentPC !== 64'h204) begin
            miscompares++;
            $display("FAIL cbz_not_taken: pc=%h, required 204", CurrentPC);
        end
        fetch($urandom, 0);
        commit(1'b0, 1'b0, 1'b1, 64'h40);
        vectors++;
        if (CurrentPC !== 64'h244) begin
            miscompares++;
            $display("FAIL uncond: pc=%h, required 244", CurrentPC);
        end
    endtask

    task automatic test_wrap();
        goto_pc(64'hFFFF_FFFF_FFFF_FFFC);
        fetch($urandom, 0);
        commit(1'b0, 1'b0, 1'b0, 64'h0);
        vectors++;
        if (CurrentPC !== 64'h0 || Fault !== 1'b0) begin
            miscompares++;
            $display("FAIL pc_wrap: pc=%h fault=%b, required 0/0", CurrentPC, Fault);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        d = $urandom;
        fetch(d, 1);
        Stall = 1'b1; ExecDone = 1'b1; Uncondbranch = 1'b1; SignExtImm64 = 64'h80;
        imem_ack = 1'b1; imem_data = ~d;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (CurrentPC !== m_pc || RetireCount !== m_cnt || InstrValid !== 1'b1 ||
                Instruction !== d || imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: pc=%h cnt=%0d valid=%b instr=%h req=%b, required %h/%0d/1/%h/0",
                         CurrentPC, RetireCount, InstrValid, Instruction, imem_req, m_pc, m_cnt, d);
            end
        end
        imem_ack = 1'b0;
        commit(1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_reset_mid_fetch();
        Reset = 1'b1;
        step();
        Reset = 1'b0; Stall = 1'b1; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        m_pc = RST_PC; m_cnt = '0; m_fault = 1'b0;
        vectors++;
        if (imem_req !== 1'b0 || Instruction !== 32'h0 || CurrentPC !== RST_PC || RetireCount !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_fetch: req=%b instr=%h pc=%h cnt=%0d", imem_req, Instruction, CurrentPC, RetireCount);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (imem_req !== 1'b0 || InstrValid !== 1'b0 || Instruction !== 32'h0) begin
                miscompares++;
                $display("FAIL stray_ack_idle: req=%b valid=%b instr=%h, required 0/0/0", imem_req, InstrValid, Instruction);
            end
        end
        imem_ack = 1'b0; Stall = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int k;
            int hold;
            k = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            fetch($urandom, k);
            for (int h = 0; h < hold; h++) begin
                Stall = 1'b1; ExecDone = ($urandom_range(0, 1) == 1);
                step();
                vectors++;
                if (CurrentPC !== m_pc || RetireCount !== m_cnt || InstrValid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rand_hold: pc=%h cnt=%0d valid=%b, required %h/%0d/1", CurrentPC, RetireCount, InstrValid, m_pc, m_cnt);
                end
            end
            ExecDone = 1'b0;
            commit(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                   {$urandom, $urandom} & ~64'h3);
        end
    endtask

    task automatic test_fault();
        logic [63:0] old_pc;
        old_pc = m_pc;
        fetch($urandom, 0);
        commit(1'b0, 1'b0, 1'b1, 64'h6);
`ifdef PC_SEQ_ALIGN_CHECK_EN
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (Fault !== 1'b1 || CurrentPC !== old_pc || imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_hold: fault=%b pc=%h req=%b, required 1/%h/0", Fault, CurrentPC, imem_req, old_pc);
            end
        end
        imem_ack = 1'b0;
`else
        vectors++;
        if (Fault !== 1'b0 || CurrentPC !== old_pc + 64'h6) begin
            miscompares++;
            $display("FAIL misaligned_load: fault=%b pc=%h, required 0/%h", Fault, CurrentPC, old_pc + 64'h6);
        end
`endif
        apply_reset();
    endtask

    initial begin
        m_pc = RST_PC; m_cnt = '0; m_fault = 1'b0;
        test_reset();
        test_basic();
        test_branch();
        test_wrap();
        test_stall();
        test_reset_mid_fetch();
        test_random();
        test_fault();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
